// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared widths, op codes, FSM state encoding and op-decode helpers for the
// memory-access stage and its load-extension helper.
package mem_access_pkg;

    localparam int AddrLen     = 32;
    localparam int RegLen      = 32;
    localparam int RegAddrLen  = 5;
    localparam int OpLen       = 6;
    localparam int RamDataLen  = 8;
    localparam int MemStateLen = 2;

    localparam logic [OpLen-1:0] OpNop = 6'h00;
    localparam logic [OpLen-1:0] OpAdd = 6'h01;
    localparam logic [OpLen-1:0] OpSub = 6'h02;
    localparam logic [OpLen-1:0] OpLb  = 6'h10;
    localparam logic [OpLen-1:0] OpLh  = 6'h11;
    localparam logic [OpLen-1:0] OpLw  = 6'h12;
    localparam logic [OpLen-1:0] OpLbu = 6'h13;
    localparam logic [OpLen-1:0] OpLhu = 6'h14;
    localparam logic [OpLen-1:0] OpSb  = 6'h18;
    localparam logic [OpLen-1:0] OpSh  = 6'h19;
    localparam logic [OpLen-1:0] OpSw  = 6'h1A;

    typedef enum logic [MemStateLen-1:0] {
        MemIdle  = 2'd0,
        MemLoad  = 2'd1,
        MemStore = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [OpLen-1:0] op);
        return (op == OpLb) || (op == OpLh) || (op == OpLw) ||
               (op == OpLbu) || (op == OpLhu);
    endfunction

    function automatic logic is_store(input logic [OpLen-1:0] op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

    // Transfer size in bytes; 0 for anything that does not touch memory.
    function automatic logic [2:0] op_size(input logic [OpLen-1:0] op);
        logic [2:0] n;
        n = 3'd0;
        if ((op == OpLb) || (op == OpLbu) || (op == OpSb)) n = 3'd1;
        if ((op == OpLh) || (op == OpLhu) || (op == OpSh)) n = 3'd2;
        if ((op == OpLw) || (op == OpSw))                  n = 3'd4;
        return n;
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// load_ext
// Combinational sign/zero extension of an assembled little-endian load word.
// Ports:
//   i_op    : load op code (LB/LH/LBU/LHU extend, anything else passes through)
//   i_bytes : four assembled bytes, byte 0 in bits [7:0]
//   o_word  : extended result
module load_ext
    import mem_access_pkg::*;
(
    input  logic [OpLen-1:0]  i_op,
    input  logic [RegLen-1:0] i_bytes,
    output logic [RegLen-1:0] o_word
);

    always_comb begin
        o_word = i_bytes;
        case (i_op)
            OpLb:    o_word = {{24{i_bytes[7]}}, i_bytes[7:0]};
            OpLh:    o_word = {{16{i_bytes[15]}}, i_bytes[15:0]};
            OpLbu:   o_word = {24'd0, i_bytes[7:0]};
            OpLhu:   o_word = {16'd0, i_bytes[15:0]};
            default: o_word = i_bytes;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
// Memory-access pipeline stage: performs byte-serial loads/stores over a
// byte-wide RAM port, passes non-memory results to writeback, and stalls the
// upstream stages while a transfer is in flight.
// Ports:
//   i_clk, i_rst (async, active-low), i_rdy (global freeze when low)
//   i_in_valid, i_op, i_mem_addr, i_rd_data, i_rd_addr : EX->MEM inputs
//   o_ram_a, o_ram_dout, o_ram_wr, i_ram_din           : RAM port
//   o_rd_data, o_rd_addr, o_wb_valid                    : MEM->WB outputs
//   o_mem_stall                                         : upstream hold
//
// state    | meaning
// MemIdle  | waiting for an instruction; non-memory ops retire from here
// MemLoad  | issuing byte reads and capturing returned bytes
// MemStore | writing one byte per ready cycle
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rdy,
    input  logic                  i_in_valid,
    input  logic [OpLen-1:0]      i_op,
    input  logic [AddrLen-1:0]    i_mem_addr,
    input  logic [RegLen-1:0]     i_rd_data,
    input  logic [RegAddrLen-1:0] i_rd_addr,
    output logic [AddrLen-1:0]    o_ram_a,
    output logic [RamDataLen-1:0] o_ram_dout,
    output logic                  o_ram_wr,
    input  logic [RamDataLen-1:0] i_ram_din,
    output logic [RegLen-1:0]     o_rd_data,
    output logic [RegAddrLen-1:0] o_rd_addr,
    output logic                  o_wb_valid,
    output logic                  o_mem_stall
);

    mem_state_e            r_state;
    logic [OpLen-1:0]      r_op;
    logic [AddrLen-1:0]    r_addr;
    logic [RegLen-1:0]     r_data;
    logic [RegAddrLen-1:0] r_rd;
    logic [2:0]            r_issue_idx;   // also the byte index for stores
    logic [2:0]            r_cap_idx;
    logic                  r_pending;
    logic [RegLen-1:0]     r_load_word;
    logic                  r_wb_valid;
    logic [RegLen-1:0]     r_rd_data;
    logic [RegAddrLen-1:0] r_rd_addr;

    logic [2:0]            w_size;
    logic                  w_in_is_mem;
    logic                  w_issue_fire;
    logic [2:0]            w_off;
    logic [RegLen-1:0]     w_load_next;
    logic [RegLen-1:0]     w_load_ext;

    assign w_size       = op_size(r_op);
    assign w_in_is_mem  = is_load(i_op) | is_store(i_op);
    assign w_issue_fire = (r_state == MemLoad) && i_rdy && (r_issue_idx < w_size);

    // While frozen, the read address falls back to the oldest uncaptured byte
    // (issue = capture + pending). The pending bit is held, so when rdy returns
    // the data on i_ram_din is that byte re-read, and nothing is lost or doubled.
    assign w_off = w_issue_fire ? r_issue_idx : r_cap_idx;

    always_comb begin
        w_load_next = r_load_word;
        if (r_pending)
            w_load_next[{r_cap_idx[1:0], 3'b000} +: RamDataLen] = i_ram_din;
    end

    load_ext u_load_ext (
        .i_op    (r_op),
        .i_bytes (w_load_next),
        .o_word  (w_load_ext)
    );

    always_comb begin
        o_ram_a    = '0;
        o_ram_dout = '0;
        o_ram_wr   = 1'b0;
        case (r_state)
            MemLoad: o_ram_a = r_addr + AddrLen'(w_off);
            MemStore: begin
                o_ram_a    = r_addr + AddrLen'(r_issue_idx);
                o_ram_dout = r_data[{r_issue_idx[1:0], 3'b000} +: RamDataLen];
                o_ram_wr   = i_rdy;
            end
            default: ;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign o_mem_stall = i_rst & ((r_state != MemIdle) | (i_in_valid & w_in_is_mem));
    assign o_wb_valid  = r_wb_valid & i_rdy;
    assign o_rd_data   = r_rd_data;
    assign o_rd_addr   = r_rd_addr;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= MemIdle;
            r_op        <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rd        <= '0;
            r_issue_idx <= '0;
            r_cap_idx   <= '0;
            r_pending   <= 1'b0;
            r_load_word <= '0;
            r_wb_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_addr   <= '0;
        end else if (i_rdy) begin
            r_wb_valid <= 1'b0;
            case (r_state)
                MemIdle: begin
                    if (i_in_valid) begin
                        r_op        <= i_op;
                        r_addr      <= i_mem_addr;
                        r_data      <= i_rd_data;
                        r_rd        <= i_rd_addr;
                        r_issue_idx <= '0;
                        r_cap_idx   <= '0;
                        r_pending   <= 1'b0;
                        r_load_word <= '0;
                        if (is_load(i_op)) begin
                            r_state <= MemLoad;
                        end else if (is_store(i_op)) begin
                            r_state <= MemStore;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_rd_data  <= i_rd_data;
                            r_rd_addr  <= i_rd_addr;
                        end
                    end
                end
                MemLoad: begin
                    r_pending <= w_issue_fire;
                    if (w_issue_fire)
                        r_issue_idx <= r_issue_idx + 3'd1;
                    if (r_pending) begin
                        r_load_word <= w_load_next;
                        r_cap_idx   <= r_cap_idx + 3'd1;
                        if (r_cap_idx == w_size - 3'd1) begin
                            r_state    <= MemIdle;
                            r_wb_valid <= 1'b1;
                            r_rd_data  <= w_load_ext;
                            r_rd_addr  <= r_rd;
                        end
                    end
                end
                MemStore: begin
                    r_issue_idx <= r_issue_idx + 3'd1;
                    if (r_issue_idx == w_size - 3'd1) begin
                        r_state    <= MemIdle;
                        r_wb_valid <= 1'b1;
                        r_rd_data  <= '0;
                        r_rd_addr  <= '0;
                    end
                end
                default: r_state <= MemIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid;
    logic [5:0]  op;
    logic [31:0] mem_addr, rd_data;
    logic [4:0]  rd_addr;
    logic [31:0] ram_a;
    logic [7:0]  ram_dout, ram_din;
    logic        ram_wr;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        wb_valid, mem_stall;

    logic [7:0]  ram [0:4095];
    logic        preload;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rdy       (rdy),
        .i_in_valid  (in_valid),
        .i_op        (op),
        .i_mem_addr  (mem_addr),
        .i_rd_data   (rd_data),
        .i_rd_addr   (rd_addr),
        .o_ram_a     (ram_a),
        .o_ram_dout  (ram_dout),
        .o_ram_wr    (ram_wr),
        .i_ram_din   (ram_din),
        .o_rd_data   (rd_data_o),
        .o_rd_addr   (rd_addr_o),
        .o_wb_valid  (wb_valid),
        .o_mem_stall (mem_stall)
    );

    // Byte RAM model: 4 KiB window on address bits [11:0], one-cycle read latency.
    always @(posedge clk) begin
        if (preload) begin
            ram[12'h080] <= 8'h80;
            ram[12'h100] <= 8'h78; ram[12'h101] <= 8'h56;
            ram[12'h102] <= 8'h34; ram[12'h103] <= 8'h12;
            ram[12'h300] <= 8'h34; ram[12'h301] <= 8'h92;
            ram[12'hFFE] <= 8'h11; ram[12'hFFF] <= 8'h22;
            ram[12'h000] <= 8'h33; ram[12'h001] <= 8'h44;
            ram[12'h601] <= 8'h5A;
        end else if (ram_wr) begin
            ram[ram_a[11:0]] <= ram_dout;
        end
        ram_din <= ram[ram_a[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0;
        op       = OpNop;
        mem_addr = 32'h0;
        rd_data  = 32'h0;
        rd_addr  = 5'd0;
    endtask

    task automatic drive_op(input logic [5:0] o, input logic [31:0] a,
                            input logic [31:0] d, input logic [4:0] r);
        in_valid = 1'b1;
        op       = o;
        mem_addr = a;
        rd_data  = d;
        rd_addr  = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        int          n;
        bit          is_st;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
        int          exp_wb;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        vec_t        v;
        int          got_wb;
        int          n_wb;
        logic [31:0] exp_a;
        logic [31:0] sdata;
        logic        exp_wr;

        vecs[0]  = '{OpAdd, 32'h0,        32'd5,        5'd3,  0, 1'b0, 32'd5,        5'd3,  1};
        vecs[1]  = '{OpLw,  32'h100,      32'hCAFEF00D, 5'd5,  4, 1'b0, 32'h12345678, 5'd5,  6};
        vecs[2]  = '{OpLb,  32'h80,       32'h0,        5'd6,  1, 1'b0, 32'hFFFFFF80, 5'd6,  3};
        vecs[3]  = '{OpLbu, 32'h80,       32'h0,        5'd7,  1, 1'b0, 32'h00000080, 5'd7,  3};
        vecs[4]  = '{OpLh,  32'h300,      32'h0,        5'd8,  2, 1'b0, 32'hFFFF9234, 5'd8,  4};
        vecs[5]  = '{OpLhu, 32'h300,      32'h0,        5'd9,  2, 1'b0, 32'h00009234, 5'd9,  4};
        vecs[6]  = '{6'h3F, 32'h0,        32'hDEADBEEF, 5'd31, 0, 1'b0, 32'hDEADBEEF, 5'd31, 1};
        vecs[7]  = '{OpSh,  32'h200,      32'h0000ABCD, 5'd10, 2, 1'b1, 32'h0,        5'd0,  3};
        vecs[8]  = '{OpSw,  32'h400,      32'hA1B2C3D4, 5'd11, 4, 1'b1, 32'h0,        5'd0,  5};
        vecs[9]  = '{OpLw,  32'hFFFFFFFE, 32'h0,        5'd12, 4, 1'b0, 32'h44332211, 5'd12, 6};
        vecs[10] = '{OpSb,  32'h500,      32'h000000EE, 5'd13, 1, 1'b1, 32'h0,        5'd0,  2};

        // Reset, with a load presented so the stall output must still read 0.
        rst = 1'b0;
        rdy = 1'b1;
        preload = 1'b1;
        drive_op(OpLw, 32'h100, 32'h0, 5'd1);
        @(posedge clk);
        @(negedge clk);
        chk("reset wb_valid",  {31'd0, wb_valid},  32'd0);
        chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("reset ram_wr",    {31'd0, ram_wr},    32'd0);
        chk("reset ram_a",     ram_a,              32'd0);
        chk("reset rd_data_o", rd_data_o,          32'd0);
        chk("reset rd_addr_o", {27'd0, rd_addr_o}, 32'd0);
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b1;
        next_cycle();

        // Table-driven: one instruction per entry, cycle 0 = acceptance.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            got_wb = -1;
            n_wb = 0;
            drive_op(v.op, v.addr, v.data, v.rd);
            for (int c = 0; c < 10; c++) begin
                if (c == 1) drive_idle();
                @(negedge clk);
                exp_wr = v.is_st && (c >= 1) && (c <= v.n);
                chk($sformatf("v%0d c%0d ram_wr", i, c), {31'd0, ram_wr}, {31'd0, exp_wr});
                if ((c >= 1) && (c <= v.n)) begin
                    exp_a = v.addr + 32'(c - 1);
                    chk($sformatf("v%0d c%0d ram_a", i, c), ram_a, exp_a);
                    if (v.is_st) begin
                        sdata = v.data >> (8 * (c - 1));
                        chk($sformatf("v%0d c%0d ram_dout", i, c), {24'd0, ram_dout}, {24'd0, sdata[7:0]});
                    end
                end
                chk($sformatf("v%0d c%0d mem_stall", i, c), {31'd0, mem_stall},
                    {31'd0, (v.n > 0) && (c < v.exp_wb)});
                if (wb_valid) begin
                    n_wb++;
                    if (got_wb < 0) begin
                        got_wb = c;
                        if (!v.is_st)
                            chk($sformatf("v%0d rd_data_o", i), rd_data_o, v.exp_data);
                        chk($sformatf("v%0d rd_addr_o", i), {27'd0, rd_addr_o}, {27'd0, v.exp_rd});
                    end
                end
                next_cycle();
            end
            chk($sformatf("v%0d wb cycle", i), got_wb, v.exp_wb);
            chk($sformatf("v%0d wb count", i), n_wb, 1);
        end

        chk("SW byte0", {24'd0, ram[12'h400]}, 32'hD4);
        chk("SW byte1", {24'd0, ram[12'h401]}, 32'hC3);
        chk("SW byte2", {24'd0, ram[12'h402]}, 32'hB2);
        chk("SW byte3", {24'd0, ram[12'h403]}, 32'hA1);
        chk("SH byte0", {24'd0, ram[12'h200]}, 32'hCD);
        chk("SH byte1", {24'd0, ram[12'h201]}, 32'hAB);
        chk("SB byte",  {24'd0, ram[12'h500]}, 32'hEE);

        // LW with rdy low in cycles 2 and 3: one extra cycle per gap.
        got_wb = -1;
        n_wb = 0;
        drive_op(OpLw, 32'h100, 32'h0, 5'd14);
        for (int c = 0; c < 12; c++) begin
            if (c == 1) drive_idle();
            rdy = !((c == 2) || (c == 3));
            @(negedge clk);
            chk($sformatf("gap c%0d ram_wr", c), {31'd0, ram_wr}, 32'd0);
            if (wb_valid) begin
                n_wb++;
                if (got_wb < 0) begin
                    got_wb = c;
                    chk("gap rd_data_o", rd_data_o, 32'h12345678);
                    chk("gap rd_addr_o", {27'd0, rd_addr_o}, 32'd14);
                end
            end
            next_cycle();
        end
        rdy = 1'b1;
        chk("gap wb cycle", got_wb, 8);
        chk("gap wb count", n_wb, 1);

        // ADD then SW back to back, reset asserted in the SW's second write cycle.
        drive_op(OpAdd, 32'h0, 32'd5, 5'd3);
        @(negedge clk);
        chk("b2b c0 mem_stall", {31'd0, mem_stall}, 32'd0);
        next_cycle();
        drive_op(OpSw, 32'h600, 32'h11223344, 5'd4);
        @(negedge clk);
        chk("b2b c1 wb_valid",  {31'd0, wb_valid},  32'd1);
        chk("b2b c1 rd_data_o", rd_data_o,          32'd5);
        chk("b2b c1 rd_addr_o", {27'd0, rd_addr_o}, 32'd3);
        chk("b2b c1 mem_stall", {31'd0, mem_stall}, 32'd1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("b2b c2 ram_wr",   {31'd0, ram_wr},    32'd1);
        chk("b2b c2 ram_a",    ram_a,              32'h600);
        chk("b2b c2 ram_dout", {24'd0, ram_dout},  32'h44);
        chk("b2b c2 wb_valid", {31'd0, wb_valid},  32'd0);
        next_cycle();
        chk("b2b c3 pre-rst ram_wr", {31'd0, ram_wr}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst ram_wr",    {31'd0, ram_wr},    32'd0);
        chk("rst ram_a",     ram_a,              32'd0);
        chk("rst ram_dout",  {24'd0, ram_dout},  32'd0);
        chk("rst rd_data_o", rd_data_o,          32'd0);
        chk("rst rd_addr_o", {27'd0, rd_addr_o}, 32'd0);
        chk("rst wb_valid",  {31'd0, wb_valid},  32'd0);
        chk("rst mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("post-rst mem_stall", {31'd0, mem_stall}, 32'd0);
        chk("post-rst ram_wr",    {31'd0, ram_wr},    32'd0);
        chk("post-rst wb_valid",  {31'd0, wb_valid},  32'd0);
        chk("abandoned SW byte0", {24'd0, ram[12'h600]}, 32'h44);
        chk("abandoned SW byte1", {24'd0, ram[12'h601]}, 32'h5A);
        next_cycle();

        drive_op(OpAdd, 32'h0, 32'd9, 5'd1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        chk("after-rst wb_valid",  {31'd0, wb_valid},  32'd1);
        chk("after-rst rd_data_o", rd_data_o,          32'd9);
        chk("after-rst rd_addr_o", {27'd0, rd_addr_o}, 32'd1);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
